// File: rtl/fifo_common_pkg.sv
// Shared defaults and types for the FIFO read-side streamer and its benches.
package fifo_common;

    localparam int unsigned DWIDTH_DEF     = 8;
    localparam int unsigned BURST_LEN_DEF  = 4;
    localparam int unsigned SKID_DEPTH_DEF = 2;
    localparam int unsigned WCNT_W         = 16;

    // Output word counter, wraps 65535 -> 0.
    typedef logic [WCNT_W-1:0] word_cnt_t;

    // Scoreboard match/mismatch counters used by benches around this block.
    typedef int unsigned sb_cnt_t;

    // Bits needed to encode values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small same-clock in-order buffer that absorbs the FIFO read latency.
module fifo_skid_buf
    import fifo_common::*;
#(
    parameter  int unsigned DWIDTH = DWIDTH_DEF,
    parameter  int unsigned DEPTH  = SKID_DEPTH_DEF,
    localparam int unsigned PTR_W  = cnt_w(DEPTH),
    localparam int unsigned OCC_W  = cnt_w(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_head_c,
    output logic [OCC_W-1:0]  o_occ
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic              w_do_pop;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_pop = i_pop && (r_occ != '0);
    assign o_head_c = r_mem[r_rd_ptr];
    assign o_occ    = r_occ;

    // Storage write; contents are don't-care until occupancy covers them.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keeps occupancy.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (i_push && !w_do_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!i_push && w_do_pop) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    // A push into a full buffer without a matching pop would drop a word.
    always_ff @(posedge i_clk) begin
        if (!i_res && i_push && !w_do_pop) begin
            assert (r_occ < OCC_W'(DEPTH));
        end
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains the FIFO read port into a framed valid/ready stream with error and word tracking.
module fifo_rd_streamer
    import fifo_common::*;
#(
    parameter int unsigned DWIDTH     = DWIDTH_DEF,
    parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
    parameter int unsigned SKID_DEPTH = SKID_DEPTH_DEF
) (
    input  logic              rd_clk,
    input  logic              res,
    input  logic              empty,
    input  logic              underflow,
    input  logic [DWIDTH-1:0] rdata,
    output logic              rd_en,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              err_underflow,
    output word_cnt_t         words_out
);

    localparam int unsigned OCC_W  = cnt_w(SKID_DEPTH + 1);
    localparam int unsigned CRD_W  = OCC_W + 1;
    localparam int unsigned BEAT_W = cnt_w(BURST_LEN);

    logic [OCC_W-1:0]  w_occ;
    logic [DWIDTH-1:0] w_head;
    logic [CRD_W-1:0]  w_credit;
    logic              w_pop;
    logic              w_push;
    logic              r_inflight;
    logic [BEAT_W-1:0] r_beat;
    logic              r_err;
    word_cnt_t         r_words;

    assign w_pop  = m_valid && m_ready;
    assign w_push = r_inflight && !underflow;

    // Words the buffer will hold next cycle if nothing new is requested.
    assign w_credit = CRD_W'(w_occ) + CRD_W'(r_inflight) - CRD_W'(w_pop);
    assign rd_en    = !res && !empty && (w_credit < CRD_W'(SKID_DEPTH));

    assign m_valid       = (w_occ != '0);
    assign m_data        = w_head;
    assign m_last        = m_valid && (r_beat == BEAT_W'(BURST_LEN - 1));
    assign err_underflow = r_err;
    assign words_out     = r_words;

    fifo_skid_buf #(
        .DWIDTH (DWIDTH),
        .DEPTH  (SKID_DEPTH)
    ) u_skid (
        .i_clk    (rd_clk),
        .i_res    (res),
        .i_push   (w_push),
        .i_data   (rdata),
        .i_pop    (w_pop),
        .o_head_c (w_head),
        .o_occ    (w_occ)
    );

    // Marks the cycle in which the FIFO presents the requested word.
    always_ff @(posedge rd_clk) begin
        if (res) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= rd_en;
        end
    end

    // Burst position advances only on accepted words.
    always_ff @(posedge rd_clk) begin
        if (res) begin
            r_beat <= '0;
        end else if (w_pop) begin
            if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
                r_beat <= '0;
            end else begin
                r_beat <= r_beat + BEAT_W'(1);
            end
        end
    end

    // Sticky underflow flag and accepted-word counter.
    always_ff @(posedge rd_clk) begin
        if (res) begin
            r_err   <= 1'b0;
            r_words <= '0;
        end else begin
            if (underflow) begin
                r_err <= 1'b1;
            end
            if (w_pop) begin
                r_words <= r_words + WCNT_W'(1);
            end
        end
    end

    // Credit invariant: buffered plus in-flight words never exceed the buffer.
    always_ff @(posedge rd_clk) begin
        if (!res) begin
            assert ((CRD_W'(w_occ) + CRD_W'(r_inflight)) <= CRD_W'(SKID_DEPTH));
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench: FIFO model drives the read port, monitor checks the stream.
`timescale 1ns/1ps
module tb_fifo_rd_streamer;
    import fifo_common::*;

    localparam int unsigned DW = DWIDTH_DEF;
    localparam int unsigned BL = BURST_LEN_DEF;
    localparam int unsigned SD = SKID_DEPTH_DEF;

    logic          rd_clk = 1'b0;
    logic          res;
    logic          empty;
    logic          underflow;
    logic [DW-1:0] rdata;
    logic          rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          err_underflow;
    word_cnt_t     words_out;

    fifo_rd_streamer #(
        .DWIDTH     (DW),
        .BURST_LEN  (BL),
        .SKID_DEPTH (SD)
    ) dut (
        .rd_clk        (rd_clk),
        .res           (res),
        .empty         (empty),
        .underflow     (underflow),
        .rdata         (rdata),
        .rd_en         (rd_en),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .err_underflow (err_underflow),
        .words_out     (words_out)
    );

    always #5 rd_clk = ~rd_clk;

    sb_cnt_t       n_cmp = 0;
    sb_cnt_t       n_bad = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW:0]   exp_q[$];
    logic          rd_pend  = 1'b0;
    logic [DW-1:0] rd_word  = '0;
    int unsigned   push_idx = 0;
    int unsigned   rd_cnt   = 0;
    word_cnt_t     mdl_words = '0;
    logic          mdl_err  = 1'b0;
    logic          armed    = 1'b0;
    logic          done     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One rd_clk cycle: drive inputs at negedge, model the FIFO read port.
    task automatic step(input logic res_v, input logic rdy_v, input logic uf_v);
        @(negedge rd_clk);
        res       = res_v;
        m_ready   = rdy_v;
        underflow = uf_v;
        if (rd_pend) begin
            rdata = rd_word;
            if (!res_v && !uf_v) begin
                exp_q.push_back({((push_idx % BL) == (BL - 1)), rd_word});
                push_idx++;
            end
        end else begin
            rdata = DW'($urandom);
        end
        if (res_v) begin
            exp_q.delete();
            push_idx = 0;
        end
        empty = (fifo_q.size() == 0);
        #1;
        if (res_v) chk("rd_en_in_reset", 32'(rd_en), 32'(0));
        if (empty) chk("rd_en_when_empty", 32'(rd_en), 32'(0));
        if (!res_v) chk("credit_bound", 32'(exp_q.size() <= SD), 32'(1));
        rd_pend = 1'b0;
        if (rd_en && fifo_q.size() != 0) begin
            rd_pend = 1'b1;
            rd_word = fifo_q.pop_front();
            rd_cnt++;
        end
    endtask

    // Monitor: checks accepted words, holding, counters and error flag.
    initial begin : monitor
        logic          hold;
        logic [DW-1:0] held;
        logic [DW:0]   e;
        hold = 1'b0;
        held = '0;
        while (!done) begin
            @(negedge rd_clk);
            #2;
            if (!done) begin
                if (armed) begin
                    chk("words_out", 32'(words_out), 32'(mdl_words));
                    chk("err_underflow", 32'(err_underflow), 32'(mdl_err));
                end
                if (res) begin
                    armed     = 1'b1;
                    hold      = 1'b0;
                    mdl_words = '0;
                    mdl_err   = 1'b0;
                end else if (armed) begin
                    if (hold) begin
                        chk("hold_valid", 32'(m_valid), 32'(1));
                        chk("hold_data", 32'(m_data), 32'(held));
                    end
                    if (!m_valid) chk("last_idle", 32'(m_last), 32'(0));
                    if (m_valid && m_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL pop_unexpected: got data 0x%0h expected no word", m_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("data", 32'(m_data), 32'(e[DW-1:0]));
                            chk("last", 32'(m_last), 32'(e[DW]));
                        end
                        mdl_words++;
                    end
                    if (underflow) mdl_err = 1'b1;
                    hold = m_valid && !m_ready;
                    held = m_data;
                end
            end
        end
    end

    initial begin : main
        res       = 1'b1;
        empty     = 1'b1;
        underflow = 1'b0;
        m_ready   = 1'b0;
        rdata     = '0;

        // Reset with data waiting, then stream 0x10..0x17.
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(32'h10 + i));
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("lat_c0_valid", 32'(m_valid), 32'(0));
        chk("lat_c0_rd_en", 32'(rd_en), 32'(1));
        step(1'b0, 1'b1, 1'b0);
        chk("lat_c1_valid", 32'(m_valid), 32'(0));
        step(1'b0, 1'b1, 1'b0);
        chk("lat_c2_valid", 32'(m_valid), 32'(1));
        chk("lat_c2_data", 32'(m_data), 32'h10);
        repeat (10) step(1'b0, 1'b1, 1'b0);
        chk("stream_words_out", 32'(words_out), 32'd8);

        // Backpressure: only two reads issued while stalled.
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(32'h10 + i));
        rd_cnt = 0;
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("bp_rd_en_pulses", rd_cnt, 32'd2);
        chk("bp_head_valid", 32'(m_valid), 32'(1));
        chk("bp_head_data", 32'(m_data), 32'h10);
        repeat (14) step(1'b0, 1'b1, 1'b0);
        chk("bp_words_out", 32'(words_out), 32'd16);

        // Toggled ready over 12 words.
        for (int i = 0; i < 12; i++) fifo_q.push_back(DW'(32'h20 + i));
        for (int i = 0; i < 40; i++) step(1'b0, i[0], 1'b0);
        chk("tog_words_out", 32'(words_out), 32'd28);

        // Underflow on the first capture drops that word and sets the flag.
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(32'h30 + i));
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, rd_pend);
        repeat (12) step(1'b0, 1'b1, 1'b0);
        chk("uf_err_sticky", 32'(err_underflow), 32'(1));
        chk("uf_words_out", 32'(words_out), 32'd33);

        // Mid-burst reset after two words of a fresh burst.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_err_cleared", 32'(err_underflow), 32'(0));
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(32'h40 + i));
        for (int g = 0; g < 20; g++) begin
            if (mdl_words >= 2) break;
            step(1'b0, 1'b1, 1'b0);
        end
        chk("mb_words_before_rst", 32'(words_out), 32'd2);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("mb_valid_after_rst", 32'(m_valid), 32'(0));
        chk("mb_words_after_rst", 32'(words_out), 32'(0));
        repeat (14) step(1'b0, 1'b1, 1'b0);

        // Randomized traffic with occasional underflow and reset.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) fifo_q.push_back(DW'($urandom));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0));
        end

        // Drain everything still queued or buffered.
        for (int g = 0; g < 200; g++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !rd_pend) break;
            step(1'b0, 1'b1, 1'b0);
        end
        chk("drain_complete", 32'(exp_q.size() + fifo_q.size()) + 32'(rd_pend), 32'(0));
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        done = 1'b1;
        @(negedge rd_clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
